pipe_stage_buf: RTL

Parametrised, elastic pipeline stage register for the pipelined datapath. It is the generic successor to the fixed per-boundary latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary-width payload plus a control field that is zeroed on bubbles. It provides a valid/ready handshake with a 2-entry skid buffer, flush, external hold (cache-miss stall), sticky halt detection and a saturating stall counter. One instance sits at every stage boundary of the CPU.

---
 rtl/pipe_stage_buf.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
//
// Elastic pipeline stage register placed at every CPU stage boundary.
// It holds up to two beats: a main entry that drives the outputs and a skid
// entry that catches the one beat already in flight when downstream stalls.
// This keeps in_ready a purely registered signal, so there is no
// combinational ready chain across stages.
//
// Parameters
//   DW   payload width
//   CW   control-field width (zeroed on bubbles)
//   SCW  stall-counter width
//
// Ports
//   CLK, nRST              clock, asynchronous active-low reset
//   in_valid/in_ready      upstream handshake
//   in_data/in_ctrl/in_halt upstream beat
//   out_valid/out_ready    downstream handshake
//   out_data/out_ctrl/out_halt main-entry beat (ctrl/halt gated by valid)
//   hold                   global freeze (cache miss)
//   flush                  squash stage contents
//   halted                 sticky, set when a halt beat leaves the stage
//   stall_cnt              saturating count of downstream-blocked cycles
//   occupancy              number of entries held (0..2)
// ---------------------------------------------------------------------------
module pipe_stage_buf #(
    parameter int DW  = 128,
    parameter int CW  = 16,
    parameter int SCW = 16
) (
    input  logic           CLK,
    input  logic           nRST,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  in_data,
    input  logic [CW-1:0]  in_ctrl,
    input  logic           in_halt,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_data,
    output logic [CW-1:0]  out_ctrl,
    output logic           out_halt,
    input  logic           hold,
    input  logic           flush,
    output logic           halted,
    output logic [SCW-1:0] stall_cnt,
    output logic [1:0]     occupancy
);

    // Occupancy encodings of {main_v, skid_v}; 2'b01 is illegal.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic           main_v_q,    main_v_d;
    logic [DW-1:0]  main_data_q, main_data_d;
    logic [CW-1:0]  main_ctrl_q, main_ctrl_d;
    logic           main_halt_q, main_halt_d;
    logic           skid_v_q,    skid_v_d;
    logic [DW-1:0]  skid_data_q, skid_data_d;
    logic [CW-1:0]  skid_ctrl_q, skid_ctrl_d;
    logic           skid_halt_q, skid_halt_d;
    logic           halted_q,    halted_d;
    logic [SCW-1:0] stall_cnt_q, stall_cnt_d;

    logic in_fire;
    logic out_fire;

    assign in_ready = !skid_v_q && !hold && !halted_q;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = main_v_q && out_ready && !hold;

    always_comb begin
        main_v_d    = main_v_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        main_halt_d = main_halt_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_halt_d = skid_halt_q;

        if (flush) begin
            // Flush wins over everything, including hold. A beat leaving
            // this cycle was still captured downstream; anything arriving
            // is dropped.
            main_v_d    = 1'b0;
            main_ctrl_d = '0;
            main_halt_d = 1'b0;
            skid_v_d    = 1'b0;
            skid_ctrl_d = '0;
            skid_halt_d = 1'b0;
        end else if (!hold) begin
            case ({main_v_q, skid_v_q})
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_v_d    = 1'b1;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        main_halt_d = in_halt;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        main_halt_d = in_halt;
                    end else if (in_fire) begin
                        // Downstream blocked: park the younger beat in skid.
                        skid_v_d    = 1'b1;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        skid_halt_d = in_halt;
                    end else if (out_fire) begin
                        main_v_d = 1'b0;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain path exists.
                    if (out_fire) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        main_halt_d = skid_halt_q;
                        skid_v_d    = 1'b0;
                    end
                end
                default: begin
                    // Skid without main cannot be reached; fall back to empty.
                    main_v_d = 1'b0;
                    skid_v_d = 1'b0;
                end
            endcase
        end
    end

    assign halted_d = halted_q || (out_fire && main_halt_q);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_v_q && !out_ready && !hold && (stall_cnt_q != {SCW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(SCW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            main_v_q    <= 1'b0;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            main_halt_q <= 1'b0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_halt_q <= 1'b0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            main_v_q    <= main_v_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            main_halt_q <= main_halt_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_halt_q <= skid_halt_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = main_v_q;
    assign out_data  = main_data_q;
    // Bubbles present an all-zero control word so downstream sees a NOP.
    assign out_ctrl  = main_v_q ? main_ctrl_q : '0;
    assign out_halt  = main_v_q && main_halt_q;
    assign halted    = halted_q;
    assign stall_cnt = stall_cnt_q;
    assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

endmodule
